multicycle_control_fsm: RTL and testbench

//  Moore/Mealy control sequencer for the multi-cycle MIPS datapath: breaks each instruction into FETCH/DECODE/EXEC/MEM/WB

---
 rtl/multicycle_control_fsm.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and mux selects, counts retired instructions and flags unsupported opcodes.
module multicycle_control_fsm #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_beq,
    output logic               pc_write_bne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [3:0]         state_out,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [3:0]         state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire;

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 3'b000;
        pc_source    = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:              state_d = S_R_EXEC;
                    OP_ADDI, OP_ORI,
                    OP_LUI:                state_d = S_I_EXEC;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:        state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ORI:  alu_op = 3'b010;
                    OP_LUI:  alu_op = 3'b011;
                    default: alu_op = 3'b000;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = 3'b001;
                pc_source    = 2'b01;
                pc_write_beq = (opcode == OP_BEQ);
                pc_write_bne = (opcode == OP_BNE);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            // Unused encodings recover to FETCH rather than locking up.
            default: state_d = S_FETCH;
        endcase

        count_d = retire ? count_q + {{(COUNT_W-1){1'b0}}, 1'b1} : count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign state_out   = state_q;
    assign illegal_op  = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction model builds the expected cycle trace,
// one compare process checks every cycle; a second instance with COUNT_W=4 checks counter wrap.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctrl_t       c;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [3:0]  state_out;
    logic [31:0] instr_count;

    logic        w_pcw, w_beq, w_bne, w_iord, w_mr, w_mw, w_irw, w_rd, w_m2r, w_rw, w_asa, w_ill;
    logic [1:0]  w_asb, w_pcs;
    logic [2:0]  w_aop;
    logic [3:0]  w_state;
    logic [3:0]  w_count;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] model_count = '0;
    logic        model_illegal = 1'b0;
    ctrl_t       act;

    multicycle_control_fsm #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state_out(state_out), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    multicycle_control_fsm #(.COUNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(w_pcw), .pc_write_beq(w_beq), .pc_write_bne(w_bne),
        .i_or_d(w_iord), .mem_read(w_mr), .mem_write(w_mw), .ir_write(w_irw),
        .reg_dst(w_rd), .mem_to_reg(w_m2r), .reg_write(w_rw),
        .alu_src_a(w_asa), .alu_src_b(w_asb), .alu_op(w_aop), .pc_source(w_pcs),
        .state_out(w_state), .illegal_op(w_ill), .instr_count(w_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    always_comb act = {pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    // scoreboard: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", 64'(state_out), 64'(e.st));
            check("ctrl", 64'(act), 64'(e.c));
            check("count", 64'(instr_count), 64'(e.cnt));
            check("illegal", 64'(illegal_op), 64'(e.ill));
            check("count_w4", 64'(w_count), 64'(e.cnt[3:0]));
        end
    end

    // drivers
    task automatic step(input logic [3:0] st, input ctrl_t c, input logic mr, input logic [5:0] op,
                        input logic rst_n, input logic ret);
        reset     = rst_n;
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back({st, c, model_count, model_illegal});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_count   = '0;
            model_illegal = 1'b0;
        end else if (ret) begin
            model_count = model_count + 32'd1;
        end
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'($urandom);
        repeat (n) @(posedge clk);
        #1;
        model_count   = '0;
        model_illegal = 1'b0;
    endtask

    // abort_at >= 0 pulls reset low on that MEM_WR wait cycle
    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                             input int abort_at, output int cycles);
        ctrl_t c;
        cycles = 0;
        for (int w = 0; w <= fwait; w++) begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            c.ir_write = (w == fwait); c.pc_write = (w == fwait);
            step(4'd0, c, (w == fwait), 6'($urandom), 1'b1, 1'b0);
            cycles++;
        end
        c = '0; c.alu_src_b = 2'b11;
        step(4'd1, c, 1'($urandom), op, 1'b1, 1'b0);
        cycles++;
        case (op)
            6'h00: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b111;
                step(4'd6, c, 1'($urandom), op, 1'b1, 1'b0);
                c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                step(4'd7, c, 1'($urandom), op, 1'b1, 1'b1);
                cycles += 2;
            end
            6'h08, 6'h0D, 6'h0F: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                c.alu_op = (op == 6'h08) ? 3'b000 : (op == 6'h0D) ? 3'b010 : 3'b011;
                step(4'd8, c, 1'($urandom), op, 1'b1, 1'b0);
                c = '0; c.reg_write = 1'b1;
                step(4'd9, c, 1'($urandom), op, 1'b1, 1'b1);
                cycles += 2;
            end
            6'h23, 6'h2B: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                step(4'd2, c, 1'($urandom), op, 1'b1, 1'b0);
                cycles++;
                if (op == 6'h23) begin
                    for (int w = 0; w <= mwait; w++) begin
                        c = '0; c.mem_read = 1'b1; c.i_or_d = 1'b1;
                        step(4'd3, c, (w == mwait), op, 1'b1, 1'b0);
                        cycles++;
                    end
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    step(4'd4, c, 1'($urandom), op, 1'b1, 1'b1);
                    cycles++;
                end else begin
                    for (int w = 0; w <= mwait; w++) begin
                        c = '0; c.mem_write = 1'b1; c.i_or_d = 1'b1;
                        if (w == abort_at) begin
                            step(4'd5, c, 1'b0, op, 1'b0, 1'b0);
                            cycles++;
                            return;
                        end
                        step(4'd5, c, (w == mwait), op, 1'b1, (w == mwait));
                        cycles++;
                    end
                end
            end
            6'h04, 6'h05: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_source = 2'b01;
                c.pc_write_beq = (op == 6'h04); c.pc_write_bne = (op == 6'h05);
                step(4'd10, c, 1'($urandom), op, 1'b1, 1'b1);
                cycles++;
            end
            6'h02: begin
                c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10;
                step(4'd11, c, 1'($urandom), op, 1'b1, 1'b1);
                cycles++;
            end
            default: model_illegal = 1'b1;
        endcase
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) step(4'd15, ctrl_t'('0), 1'($urandom), 6'($urandom), 1'b1, 1'b0);
    endtask

    initial begin
        int cyc;
        do_reset(2);
        check("reset_state", 64'(state_out), 64'd0);
        check("reset_count", 64'(instr_count), 64'd0);
        check("reset_illegal", 64'(illegal_op), 64'd0);
        check("reset_mem_read", 64'(mem_read), 64'd1);

        run_instr(6'h00, 0, 0, -1, cyc); check("cycles_rtype", 64'(cyc), 64'd4);
        check("count_after_r", 64'(instr_count), 64'd1);
        run_instr(6'h08, 0, 0, -1, cyc); check("cycles_addi", 64'(cyc), 64'd4);
        run_instr(6'h0D, 2, 0, -1, cyc); check("cycles_ori_fwait2", 64'(cyc), 64'd6);
        run_instr(6'h0F, 0, 0, -1, cyc);
        run_instr(6'h23, 0, 3, -1, cyc); check("cycles_lw_wait3", 64'(cyc), 64'd8);
        run_instr(6'h23, 0, 0, -1, cyc); check("cycles_lw", 64'(cyc), 64'd5);
        run_instr(6'h2B, 0, 1, -1, cyc); check("cycles_sw_wait1", 64'(cyc), 64'd5);
        run_instr(6'h2B, 0, 0, -1, cyc); check("cycles_sw", 64'(cyc), 64'd4);
        run_instr(6'h04, 0, 0, -1, cyc); check("cycles_beq", 64'(cyc), 64'd3);
        run_instr(6'h05, 1, 0, -1, cyc); check("cycles_bne_fwait1", 64'(cyc), 64'd4);
        run_instr(6'h02, 0, 0, -1, cyc); check("cycles_j", 64'(cyc), 64'd3);
        check("count_after_11", 64'(instr_count), 64'd11);

        run_instr(6'h3F, 0, 0, -1, cyc);
        halt_cycles(10);
        check("halt_state", 64'(state_out), 64'd15);
        check("halt_illegal", 64'(illegal_op), 64'd1);
        check("halt_count", 64'(instr_count), 64'd11);
        do_reset(1);
        check("post_halt_state", 64'(state_out), 64'd0);
        check("post_halt_illegal", 64'(illegal_op), 64'd0);

        run_instr(6'h02, 0, 0, -1, cyc);
        run_instr(6'h2B, 0, 3, 1, cyc);
        check("abort_count", 64'(instr_count), 64'd0);
        check("abort_state", 64'(state_out), 64'd0);

        for (int i = 0; i < 16; i++) run_instr(6'h02, 0, 0, -1, cyc);
        check("wrap_count_w4", 64'(w_count), 64'd0);
        check("count_after_16", 64'(instr_count), 64'd16);
        run_instr(6'h0D, 0, 0, -1, cyc);
        check("wrap_plus1_w4", 64'(w_count), 64'd1);

        halt_cycles(0);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
